// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline requesters, the unified memory and the port arbiter.
// The arbiter takes the slave view; the pipeline/memory side takes the master view.
interface mem_port_arbiter_if;
    logic if_req;
    logic d_req;
    logic d_we;
    logic mem_done;
    logic sig_mux_select;
    logic mem_req;
    logic mem_we;
    logic if_done;
    logic d_done;
    logic if_stall;
    logic d_stall;
    logic sig_error;

    modport slave (
        input  if_req, d_req, d_we, mem_done,
        output sig_mux_select, mem_req, mem_we, if_done, d_done, if_stall, d_stall, sig_error
    );

    modport master (
        output if_req, d_req, d_we, mem_done,
        input  sig_mux_select, mem_req, mem_we, if_done, d_done, if_stall, d_stall, sig_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, with a
// fetch starvation guard and a sticky watchdog timeout on the memory.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 3,
    parameter int unsigned TIMEOUT         = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       we_q, we_d;
    logic [3:0] streak_q, streak_d;
    logic [7:0] timer_q, timer_d;
    logic       error_q, error_d;
    logic       timeout_hit;
    logic       finish;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            streak_q <= '0;
            timer_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        we_d        = we_q;
        streak_d    = streak_q;
        timer_d     = timer_q;
        error_d     = error_q;
        // A late mem_done on the last watchdog cycle still counts as a normal completion.
        timeout_hit = (state_q != IDLE) && !bus.mem_done && (timer_q == TIMER_LAST);
        finish      = (state_q != IDLE) && (bus.mem_done || timeout_hit);

        unique case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && streak_q == STREAK_MAX)) begin
                    state_d = BUSY_D;
                    sel_d   = 1'b1;
                    we_d    = bus.d_we;
                    timer_d = '0;
                    if (bus.if_req && streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (bus.if_req) begin
                    state_d  = BUSY_I;
                    sel_d    = 1'b0;
                    we_d     = 1'b0;
                    timer_d  = '0;
                    streak_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    error_d = error_q | timeout_hit;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sig_mux_select = sel_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_req        = (state_q != IDLE);
    assign bus.if_done        = (state_q == BUSY_I) && finish;
    assign bus.d_done         = (state_q == BUSY_D) && finish;
    assign bus.if_stall       = bus.if_req & ~bus.if_done;
    assign bus.d_stall        = bus.d_req & ~bus.d_done;
    assign bus.sig_error      = error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory model answers 2 cycles after mem_req rises.
module tb_mem_port_arbiter;

    logic clk;
    logic reset_n;
    logic mem_auto;
    logic mem_force;
    logic [7:0] mem_cnt;
    int n_checks;
    int n_pass;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_DATA_STREAK(3),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_cnt <= bus.mem_req ? mem_cnt + 8'd1 : 8'd0;
    end

    assign bus.mem_done = (mem_auto && bus.mem_req && mem_cnt == 8'd1) || mem_force;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_order;
        int grants;
        int idle_run;
        logic prev_req;

        n_checks   = 0;
        n_pass     = 0;
        mem_cnt    = 8'd0;
        reset_n    = 1'b0;
        mem_auto   = 1'b1;
        mem_force  = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a data write
        bus.d_req = 1'b1;
        bus.d_we  = 1'b1;
        tick();
        check("pre_rst_mem_req", bus.mem_req, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_sel", bus.sig_mux_select, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_if_done", bus.if_done, 0);
        check("rst_d_done", bus.d_done, 0);
        check("rst_error", bus.sig_error, 0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_mem_req", bus.mem_req, 0);
        check("post_rst_sel", bus.sig_mux_select, 0);
        check("post_rst_we", bus.mem_we, 0);
        $display("txn reset mid BUSY_D done");

        // Lone fetch
        bus.if_req = 1'b1;
        #1;
        check("if_c0_stall", bus.if_stall, 1);
        check("if_c0_mem_req", bus.mem_req, 0);
        tick();
        check("if_c1_mem_req", bus.mem_req, 1);
        check("if_c1_sel", bus.sig_mux_select, 0);
        check("if_c1_done", bus.if_done, 0);
        check("if_c1_stall", bus.if_stall, 1);
        tick();
        check("if_c2_done", bus.if_done, 1);
        check("if_c2_stall", bus.if_stall, 0);
        bus.if_req = 1'b0;
        tick();
        check("if_c3_done", bus.if_done, 0);
        check("if_c3_mem_req", bus.mem_req, 0);
        $display("txn fetch sel=0");

        // Lone data write
        bus.d_req = 1'b1;
        bus.d_we  = 1'b1;
        tick();
        check("dw_c1_sel", bus.sig_mux_select, 1);
        check("dw_c1_we", bus.mem_we, 1);
        check("dw_c1_done", bus.d_done, 0);
        check("dw_c1_stall", bus.d_stall, 1);
        tick();
        check("dw_c2_we", bus.mem_we, 1);
        check("dw_c2_done", bus.d_done, 1);
        check("dw_c2_stall", bus.d_stall, 0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
        check("dw_idle_we", bus.mem_we, 0);
        check("dw_idle_done", bus.d_done, 0);
        check("dw_idle_sel_hold", bus.sig_mux_select, 1);
        check("dw_idle_d_stall", bus.d_stall, 0);
        $display("txn data write sel=1 we=1");

        // Both requesters held: D,D,D,I,D,D,D,I (bit i = grant i is data)
        exp_order  = 8'b0111_0111;
        grants     = 0;
        idle_run   = 0;
        prev_req   = 1'b0;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        for (int c = 0; c < 100 && grants < 8; c++) begin
            tick();
            if (bus.mem_req && !prev_req) begin
                check($sformatf("grant%0d_sel", grants), bus.sig_mux_select, exp_order[grants]);
                if (grants > 0) begin
                    check($sformatf("grant%0d_gap", grants), idle_run, 1);
                end
                $display("txn contested grant %0d sel=%0d", grants, bus.sig_mux_select);
                grants++;
                idle_run = 0;
            end else if (!bus.mem_req) begin
                idle_run++;
            end
            prev_req = bus.mem_req;
        end
        if (grants < 8) begin
            check("grant_budget", grants, 8);
        end
        tick();
        check("contest_last_if_done", bus.if_done, 1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Watchdog: memory never answers a fetch
        mem_auto   = 1'b0;
        bus.if_req = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("wd_wait%0d", k), bus.if_done, 0);
            tick();
        end
        check("wd_if_done", bus.if_done, 1);
        check("wd_err_before", bus.sig_error, 0);
        check("wd_mem_req", bus.mem_req, 1);
        bus.if_req = 1'b0;
        tick();
        check("wd_idle", bus.mem_req, 0);
        check("wd_err_set", bus.sig_error, 1);
        $display("txn fetch timed out");
        mem_auto  = 1'b1;
        bus.d_req = 1'b1;
        bus.d_we  = 1'b0;
        tick();
        check("wd_rd_we", bus.mem_we, 0);
        check("wd_rd_sel", bus.sig_mux_select, 1);
        tick();
        check("wd_rd_done", bus.d_done, 1);
        bus.d_req = 1'b0;
        tick();
        check("wd_rd_idle", bus.mem_req, 0);
        check("wd_err_sticky", bus.sig_error, 1);
        $display("txn data read after timeout");

        // Stray mem_done while idle
        mem_force = 1'b1;
        #1;
        check("stray_if_done", bus.if_done, 0);
        check("stray_d_done", bus.d_done, 0);
        tick();
        mem_force = 1'b0;
        check("stray_no_state", bus.mem_req, 0);
        mem_force  = 1'b1;
        bus.if_req = 1'b1;
        tick();
        mem_force = 1'b0;
        #1;
        check("stray_grant_req", bus.mem_req, 1);
        check("stray_grant_sel", bus.sig_mux_select, 0);
        check("stray_grant_nodone", bus.if_done, 0);
        tick();
        check("stray_if_done_ok", bus.if_done, 1);
        bus.if_req = 1'b0;
        tick();
        check("stray_end_idle", bus.mem_req, 0);
        $display("txn fetch after stray mem_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
